// File: rtl/ctrl_fsm_hs.sv
// Multi-cycle instruction sequencer: fetch/decode/execute/memory/writeback handshake control
// with bus wait timeout and sticky trap reporting.
//
// state     | meaning
// FETCH     | imem request held until imem_ack, instruction latched on ack
// DECODE    | opcode legality check
// EXECUTE   | branch resolve / jump target capture / route to MEMORY or WRITEBACK
// MEMORY    | dmem request held until dmem_ack
// WRITEBACK | single-cycle register and PC write
// TRAP      | all requests idle, cause held until reset
module ctrl_fsm_hs #(
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [6:0]      opcode_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] alu_result_i,
    input  logic [XLEN-1:0] pc_plus4_i,
    output logic            imem_req_o,
    input  logic            imem_ack_i,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    input  logic            dmem_ack_i,
    output logic [1:0]      dmem_size_o,
    output logic            dmem_sign_o,
    output logic            ir_we_o,
    output logic            reg_we_o,
    output logic [1:0]      wb_sel_o,
    output logic            pc_we_o,
    output logic [XLEN-1:0] next_pc_o,
    output logic [2:0]      state_o,
    output logic            trap_o,
    output logic [1:0]      trap_cause_o
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);
    localparam logic [CW-1:0] WAIT_SAT  = CW'(MAX_WAIT);

    localparam logic [2:0] S_FETCH     = 3'd0;
    localparam logic [2:0] S_DECODE    = 3'd1;
    localparam logic [2:0] S_EXECUTE   = 3'd2;
    localparam logic [2:0] S_MEMORY    = 3'd3;
    localparam logic [2:0] S_WRITEBACK = 3'd4;
    localparam logic [2:0] S_TRAP      = 3'd5;

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_I      = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
    localparam logic [1:0] CAUSE_ALIGN   = 2'b11;

    logic [2:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] tgt_q, tgt_d;
    logic            trap_q, trap_d;
    logic [1:0]      cause_q, cause_d;

    logic            is_load, is_store, is_branch, is_jump, legal;
    logic            br_taken, misaligned, timeout, wait_state;
    logic [XLEN-1:0] target;

    assign is_load    = (opcode_i == OP_LOAD);
    assign is_store   = (opcode_i == OP_STORE);
    assign is_branch  = (opcode_i == OP_BRANCH);
    assign is_jump    = (opcode_i == OP_JAL) || (opcode_i == OP_JALR);
    assign target     = {alu_result_i[XLEN-1:1], 1'b0};
    assign misaligned = target[1];
    assign wait_state = (state_q == S_FETCH) || (state_q == S_MEMORY);
    // Evaluated only when no ack is present, so a same-cycle ack always wins.
    assign timeout    = (cnt_q >= WAIT_LAST);

    always_comb begin
        legal = 1'b0;
        case (opcode_i)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal = 1'b1;
            default:                           legal = 1'b0;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        case (funct3_i)
            3'b000, 3'b101, 3'b111: br_taken = (alu_result_i == '0);
            3'b001:                 br_taken = (alu_result_i != '0);
            3'b100, 3'b110:         br_taken = (alu_result_i == XLEN'(1));
            default:                br_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        trap_d      = trap_q;
        cause_d     = cause_q;
        imem_req_o  = 1'b0;
        ir_we_o     = 1'b0;
        dmem_req_o  = 1'b0;
        dmem_we_o   = 1'b0;
        dmem_size_o = 2'b00;
        dmem_sign_o = 1'b0;
        reg_we_o    = 1'b0;
        wb_sel_o    = 2'b00;
        pc_we_o     = 1'b0;
        next_pc_o   = '0;
        case (state_q)
            S_FETCH: begin
                // Gated by rst_n so nothing is requested while reset is held.
                imem_req_o = rst_n;
                if (imem_ack_i) begin
                    ir_we_o = rst_n;
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                if (legal) begin
                    state_d = S_EXECUTE;
                end else begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_ILLEGAL;
                end
            end
            S_EXECUTE: begin
                if (is_branch) begin
                    if (br_taken && misaligned) begin
                        state_d = S_TRAP;
                        trap_d  = 1'b1;
                        cause_d = CAUSE_ALIGN;
                    end else begin
                        pc_we_o   = 1'b1;
                        next_pc_o = br_taken ? target : pc_plus4_i;
                        state_d   = S_FETCH;
                    end
                end else if (is_jump) begin
                    if (misaligned) begin
                        state_d = S_TRAP;
                        trap_d  = 1'b1;
                        cause_d = CAUSE_ALIGN;
                    end else begin
                        tgt_d   = target;
                        state_d = S_WRITEBACK;
                    end
                end else if (is_load || is_store) begin
                    state_d = S_MEMORY;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                dmem_req_o  = 1'b1;
                dmem_we_o   = is_store;
                dmem_size_o = (funct3_i[1:0] == 2'b11) ? 2'b10 : funct3_i[1:0];
                dmem_sign_o = is_store | ~funct3_i[2];
                if (dmem_ack_i) begin
                    if (is_store) begin
                        pc_we_o   = 1'b1;
                        next_pc_o = pc_plus4_i;
                        state_d   = S_FETCH;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end else if (timeout) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_WRITEBACK: begin
                reg_we_o  = 1'b1;
                pc_we_o   = 1'b1;
                wb_sel_o  = is_load ? 2'b01 : (is_jump ? 2'b10 : 2'b00);
                next_pc_o = is_jump ? tgt_q : pc_plus4_i;
                state_d   = S_FETCH;
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        if ((state_d != state_q) || !wait_state) begin
            cnt_d = '0;
        end else if (cnt_q == WAIT_SAT) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            tgt_q   <= '0;
            trap_q  <= 1'b0;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            trap_q  <= trap_d;
            cause_q <= cause_d;
        end
    end

    assign state_o      = state_q;
    assign trap_o       = trap_q;
    assign trap_cause_o = cause_q;

endmodule

// File: tb/tb_ctrl_fsm_hs.sv
// Directed bench for ctrl_fsm_hs: expected PC-write events are queued as each
// instruction is set up and checked when the DUT pulses pc_we.
module tb_ctrl_fsm_hs;

    localparam int XLEN     = 32;
    localparam int MAX_WAIT = 4;

    localparam logic [6:0] OP_I      = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [6:0]      opcode = '0;
    logic [2:0]      funct3 = '0;
    logic [XLEN-1:0] alu_result = '0;
    logic [XLEN-1:0] pc_plus4 = '0;
    logic            imem_ack = 1'b0;
    logic            dmem_ack = 1'b0;
    logic            imem_req_o, dmem_req_o, dmem_we_o, dmem_sign_o;
    logic            ir_we_o, reg_we_o, pc_we_o, trap_o;
    logic [1:0]      dmem_size_o, wb_sel_o, trap_cause_o;
    logic [XLEN-1:0] next_pc_o;
    logic [2:0]      state_o;

    always #5 clk = ~clk;

    ctrl_fsm_hs #(.XLEN(XLEN), .MAX_WAIT(MAX_WAIT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode_i     (opcode),
        .funct3_i     (funct3),
        .alu_result_i (alu_result),
        .pc_plus4_i   (pc_plus4),
        .imem_req_o   (imem_req_o),
        .imem_ack_i   (imem_ack),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_ack_i   (dmem_ack),
        .dmem_size_o  (dmem_size_o),
        .dmem_sign_o  (dmem_sign_o),
        .ir_we_o      (ir_we_o),
        .reg_we_o     (reg_we_o),
        .wb_sel_o     (wb_sel_o),
        .pc_we_o      (pc_we_o),
        .next_pc_o    (next_pc_o),
        .state_o      (state_o),
        .trap_o       (trap_o),
        .trap_cause_o (trap_cause_o)
    );

    typedef struct {
        logic [31:0] npc;
        logic        rwe;
        logic [1:0]  wsel;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   ir_cnt = 0;
    int   start;

    logic [2:0]  br_f3  [11] = '{3'b000, 3'b001, 3'b001, 3'b100, 3'b100, 3'b111,
                                 3'b010, 3'b000, 3'b110, 3'b000, 3'b101};
    logic [31:0] br_alu [11] = '{32'h100, 32'h0, 32'h100, 32'h1, 32'h0, 32'h0,
                                 32'h0, 32'h0, 32'h3, 32'h102, 32'h0};
    logic        br_tk  [11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
                                 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [6:0]  oth_op [3]  = '{7'h37, 7'h17, 7'h33};
    logic [2:0]  ld_f3  [4]  = '{3'b001, 3'b100, 3'b011, 3'b010};
    logic [1:0]  ld_sz  [4]  = '{2'b01, 2'b00, 2'b10, 2'b10};
    logic        ld_sg  [4]  = '{1'b1, 1'b0, 1'b1, 1'b1};
    int          ld_wt  [4]  = '{3, 0, 1, 2};
    logic [2:0]  st_f3  [3]  = '{3'b000, 3'b001, 3'b010};
    logic [1:0]  st_sz  [3]  = '{2'b00, 2'b01, 2'b10};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] npc, input logic rwe, input logic [1:0] wsel);
        exp_t e;
        e.npc  = npc;
        e.rwe  = rwe;
        e.wsel = wsel;
        sb.push_back(e);
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3,
                             input logic [31:0] alu, input logic [31:0] pc4);
        opcode     = op;
        funct3     = f3;
        alu_result = alu;
        pc_plus4   = pc4;
    endtask

    // Observe the current cycle (scoreboard on pc_we), then move past the next rising edge.
    task automatic cycle();
        exp_t e;
        #1;
        if (ir_we_o === 1'b1) ir_cnt++;
        if (pc_we_o !== 1'b0) begin
            if (sb.size() == 0) begin
                check("pc_we_unexpected", 64'(pc_we_o), 64'd0);
            end else begin
                e = sb.pop_front();
                check("next_pc", 64'(next_pc_o), 64'(e.npc));
                check("reg_we_with_pc_we", 64'(reg_we_o), 64'(e.rwe));
                if (e.rwe) check("wb_sel", 64'(wb_sel_o), 64'(e.wsel));
            end
        end else if (reg_we_o !== 1'b0) begin
            check("reg_we_without_pc_we", 64'(reg_we_o), 64'd0);
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input int waits);
        imem_ack = 1'b0;
        for (int i = 0; i < waits; i++) begin
            #1;
            check("fetch_imem_req", 64'(imem_req_o), 64'd1);
            cycle();
        end
        imem_ack = 1'b1;
        #1;
        check("fetch_ir_we", 64'(ir_we_o), 64'd1);
        cycle();
        imem_ack = 1'b0;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        @(posedge clk);
        #1;
        check("rst_state", 64'(state_o), 64'd0);
        check("rst_trap", 64'(trap_o), 64'd0);
        check("rst_cause", 64'(trap_cause_o), 64'd0);
        check("rst_imem_req", 64'(imem_req_o), 64'd0);
        check("rst_pc_we", 64'(pc_we_o), 64'd0);
        check("rst_next_pc", 64'(next_pc_o), 64'd0);
        rst_n = 1'b1;
        #1;
        check("rel_imem_req", 64'(imem_req_o), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, observed no summary, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // ADDI, ack after two wait cycles
        set_instr(OP_I, 3'b000, 32'h55, 32'h104);
        push_exp(32'h104, 1'b1, 2'b00);
        start  = cyc;
        ir_cnt = 0;
        fetch(2);
        check("addi_decode", 64'(state_o), 64'd1);
        cycle();
        check("addi_execute", 64'(state_o), 64'd2);
        cycle();
        check("addi_writeback", 64'(state_o), 64'd4);
        cycle();
        check("addi_cycles", 64'(cyc - start), 64'd6);
        check("addi_ir_we_count", 64'(ir_cnt), 64'd1);
        check("addi_fetch", 64'(state_o), 64'd0);

        for (int i = 0; i < 11; i++) begin
            set_instr(OP_BRANCH, br_f3[i], br_alu[i], 32'h1004 + 32'(i * 16));
            push_exp(br_tk[i] ? {br_alu[i][31:1], 1'b0} : pc_plus4, 1'b0, 2'b00);
            fetch(0);
            cycle();
            check("branch_execute", 64'(state_o), 64'd2);
            cycle();
            check("branch_fetch", 64'(state_o), 64'd0);
            check("branch_sb_empty", 64'(sb.size()), 64'd0);
        end

        // JAL with stray acks outside their request states
        set_instr(OP_JAL, 3'b000, 32'h2001, 32'h1004);
        push_exp(32'h2000, 1'b1, 2'b10);
        ir_cnt = 0;
        fetch(1);
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        cycle();
        cycle();
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        check("jal_writeback", 64'(state_o), 64'd4);
        cycle();
        check("jal_ir_we_count", 64'(ir_cnt), 64'd1);
        check("jal_fetch", 64'(state_o), 64'd0);

        set_instr(OP_JALR, 3'b000, 32'h3005, 32'h1104);
        push_exp(32'h3004, 1'b1, 2'b10);
        fetch(0);
        cycle();
        cycle();
        cycle();
        check("jalr_fetch", 64'(state_o), 64'd0);

        for (int i = 0; i < 3; i++) begin
            set_instr(oth_op[i], 3'b000, 32'h77, 32'h1200 + 32'(i * 4));
            push_exp(pc_plus4, 1'b1, 2'b00);
            fetch(0);
            cycle();
            cycle();
            cycle();
            check("alu_op_fetch", 64'(state_o), 64'd0);
        end

        for (int i = 0; i < 4; i++) begin
            set_instr(OP_LOAD, ld_f3[i], 32'h40, 32'h1300 + 32'(i * 4));
            push_exp(pc_plus4, 1'b1, 2'b01);
            fetch(0);
            cycle();
            cycle();
            for (int w = 0; w < ld_wt[i]; w++) begin
                #1;
                check("load_dmem_req", 64'(dmem_req_o), 64'd1);
                cycle();
            end
            dmem_ack = 1'b1;
            #1;
            check("load_dmem_we", 64'(dmem_we_o), 64'd0);
            check("load_size", 64'(dmem_size_o), 64'(ld_sz[i]));
            check("load_sign", 64'(dmem_sign_o), 64'(ld_sg[i]));
            cycle();
            dmem_ack = 1'b0;
            check("load_writeback", 64'(state_o), 64'd4);
            cycle();
            check("load_fetch", 64'(state_o), 64'd0);
        end

        for (int i = 0; i < 3; i++) begin
            set_instr(OP_STORE, st_f3[i], 32'h80, 32'h1400 + 32'(i * 4));
            push_exp(pc_plus4, 1'b0, 2'b00);
            fetch(0);
            cycle();
            cycle();
            #1;
            check("store_dmem_req", 64'(dmem_req_o), 64'd1);
            check("store_dmem_we", 64'(dmem_we_o), 64'd1);
            check("store_size", 64'(dmem_size_o), 64'(st_sz[i]));
            check("store_sign", 64'(dmem_sign_o), 64'd1);
            cycle();
            dmem_ack = 1'b1;
            cycle();
            dmem_ack = 1'b0;
            check("store_fetch", 64'(state_o), 64'd0);
            check("store_sb_empty", 64'(sb.size()), 64'd0);
        end

        // Misaligned jump target traps without any PC write
        set_instr(OP_JAL, 3'b000, 32'h2002, 32'h1504);
        fetch(0);
        cycle();
        cycle();
        check("jal_align_state", 64'(state_o), 64'd5);
        check("jal_align_trap", 64'(trap_o), 64'd1);
        check("jal_align_cause", 64'(trap_cause_o), 64'd3);
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        cycle();
        cycle();
        check("trap_hold_state", 64'(state_o), 64'd5);
        check("trap_imem_req", 64'(imem_req_o), 64'd0);
        check("trap_dmem_req", 64'(dmem_req_o), 64'd0);
        check("trap_hold_cause", 64'(trap_cause_o), 64'd3);
        do_reset();

        set_instr(OP_BRANCH, 3'b001, 32'h102, 32'h1604);
        fetch(0);
        cycle();
        cycle();
        check("br_align_state", 64'(state_o), 64'd5);
        check("br_align_cause", 64'(trap_cause_o), 64'd3);
        do_reset();

        set_instr(7'h7F, 3'b000, 32'h0, 32'h1704);
        fetch(0);
        cycle();
        check("illegal_state", 64'(state_o), 64'd5);
        check("illegal_trap", 64'(trap_o), 64'd1);
        check("illegal_cause", 64'(trap_cause_o), 64'd1);
        do_reset();

        // Fetch timeout: four unanswered cycles
        imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        check("fetch_wait_state", 64'(state_o), 64'd0);
        check("fetch_wait_trap", 64'(trap_o), 64'd0);
        cycle();
        check("fetch_timeout_state", 64'(state_o), 64'd5);
        check("fetch_timeout_cause", 64'(trap_cause_o), 64'd2);
        do_reset();

        // Ack on the fourth cycle wins over the timeout
        set_instr(OP_I, 3'b000, 32'h9, 32'h1804);
        push_exp(32'h1804, 1'b1, 2'b00);
        fetch(3);
        check("late_ack_decode", 64'(state_o), 64'd1);
        check("late_ack_trap", 64'(trap_o), 64'd0);
        cycle();
        cycle();
        cycle();
        check("late_ack_fetch", 64'(state_o), 64'd0);

        set_instr(OP_LOAD, 3'b010, 32'h40, 32'h1904);
        fetch(3);
        cycle();
        cycle();
        for (int i = 0; i < 3; i++) cycle();
        check("mem_wait_state", 64'(state_o), 64'd3);
        cycle();
        check("mem_timeout_state", 64'(state_o), 64'd5);
        check("mem_timeout_cause", 64'(trap_cause_o), 64'd2);
        do_reset();

        // Asynchronous reset in the middle of a data wait
        set_instr(OP_LOAD, 3'b010, 32'h40, 32'h1A04);
        fetch(0);
        cycle();
        cycle();
        cycle();
        check("mid_mem_state", 64'(state_o), 64'd3);
        rst_n = 1'b0;
        #1;
        check("async_rst_state", 64'(state_o), 64'd0);
        check("async_rst_dmem_req", 64'(dmem_req_o), 64'd0);
        check("async_rst_imem_req", 64'(imem_req_o), 64'd0);
        check("async_rst_trap", 64'(trap_o), 64'd0);
        do_reset();

        set_instr(OP_I, 3'b000, 32'h1, 32'h1B04);
        push_exp(32'h1B04, 1'b1, 2'b00);
        fetch(0);
        cycle();
        cycle();
        cycle();
        check("post_rst_fetch", 64'(state_o), 64'd0);
        check("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
